// File: rtl/mm_pkg.sv
// Shared types and constants for the mm operand feeder: stream widths, FSM states
// and the beats-per-operand-set helper.
package mm_pkg;

  localparam int AXIS_DW = 32;
  localparam int AXIS_KW = 4;

  typedef enum logic [1:0] {IDLE, SEND, DONE} feeder_state_t;

  function automatic int beats_per_set(input int m, input int d_w);
    return (2 * m * m) / (AXIS_DW / d_w);
  endfunction

endpackage

// File: rtl/mm_feeder_ram.sv
// Staging store for one A/B operand set: one synchronous element write port and an
// asynchronous read that returns a whole 32-bit beat. No reset, so contents persist.
module mm_feeder_ram
  import mm_pkg::*;
#(
  parameter int M   = 4,
  parameter int D_W = 8,
  localparam int DEPTH = 2 * M * M,
  localparam int AW    = $clog2(DEPTH),
  localparam int EPW   = AXIS_DW / D_W,
  localparam int NW    = beats_per_set(M, D_W),
  localparam int WW    = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic               fclk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [D_W-1:0]     i_wdata,
  input  logic [WW-1:0]      i_raddr,
  output logic [AXIS_DW-1:0] o_rdata
);

  logic [D_W-1:0] r_mem [DEPTH];

  always_ff @(posedge fclk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Lane k of word w is element w*EPW+k, lowest address in the LSBs.
  for (genvar k = 0; k < EPW; k++) begin : g_lane
    assign o_rdata[D_W*k +: D_W] = r_mem[AW'(int'(i_raddr) * EPW + k)];
  end

endmodule

// File: rtl/mm_axis_feeder.sv
// AXI4-Stream transmitter for one staged mm operand set; beat 0 valid the cycle after start,
// no bubbles under tready=1, beats held while stalled. Optional MM_FEEDER_STALL_CNT_EN stall counter.
module mm_axis_feeder
  import mm_pkg::*;
#(
  parameter int M       = 4,
  parameter int D_W     = 8,
  parameter int STALL_W = 16
) (
  input  logic                      fclk,
  input  logic                      rst,
  input  logic                      ld_en,
  input  logic [$clog2(2*M*M)-1:0]  ld_addr,
  input  logic [D_W-1:0]            ld_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [AXIS_DW-1:0]        m_axis_tdata,
  output logic [AXIS_KW-1:0]        m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [STALL_W-1:0]        stall_cnt
);

  localparam int EPW = AXIS_DW / D_W;
  localparam int NW  = beats_per_set(M, D_W);
  localparam int WW  = (NW > 1) ? $clog2(NW) : 1;

  feeder_state_t      r_state;
  logic [WW-1:0]      r_idx;
  logic [AXIS_DW-1:0] r_tdata;
  logic               r_tlast;
  logic               r_tvalid;
  logic               r_busy;
  logic               r_done;

  logic               w_wr;
  logic               w_hs;
  logic               w_last_idx;
  logic [WW-1:0]      w_rd_idx;
  logic [AXIS_DW-1:0] w_rd_word;
  logic [AXIS_DW-1:0] w_beat;

  assign w_wr       = ld_en && (r_state == IDLE);
  assign w_hs       = r_tvalid && m_axis_tready;
  assign w_last_idx = (r_idx == WW'(NW - 1));
  assign w_rd_idx   = ((r_state == SEND) && !w_last_idx) ? r_idx + WW'(1) : '0;

  mm_feeder_ram #(
    .M   (M),
    .D_W (D_W)
  ) u_ram (
    .fclk    (fclk),
    .i_we    (w_wr),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_word)
  );

  // A write landing on the same edge as start must appear in beat 0, so forward it.
  always_comb begin
    w_beat = w_rd_word;
    if (w_wr && ((int'(ld_addr) / EPW) == int'(w_rd_idx))) begin
      w_beat[D_W*(int'(ld_addr) % EPW) +: D_W] = ld_data;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= SEND;
            r_idx    <= '0;
            r_tdata  <= w_beat;
            r_tlast  <= (NW == 1);
            r_tvalid <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (w_last_idx) begin
              r_state  <= DONE;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_idx   <= w_rd_idx;
              r_tdata <= w_beat;
              r_tlast <= (w_rd_idx == WW'(NW - 1));
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;

`ifdef MM_FEEDER_STALL_CNT_EN
  logic [STALL_W-1:0] r_stall;

  always_ff @(posedge fclk) begin
    if (rst) begin
      r_stall <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall <= '0;
    end else if (r_tvalid && !m_axis_tready && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mm_axis_feeder.sv
// Scoreboard bench for mm_axis_feeder: table of element inputs and expected beats,
// plus hand-written stall, abort, reset, back-to-back and same-cycle write sequences.
module tb_mm_axis_feeder;

  localparam int NW = 8;

  logic        fclk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] stall_cnt;

  always #5 fclk = ~fclk;

  mm_axis_feeder #(.M(4), .D_W(8), .STALL_W(16)) dut (
    .fclk          (fclk),
    .rst           (rst),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .stall_cnt     (stall_cnt)
  );

  typedef struct {
    logic [7:0]  e0, e1, e2, e3;
    logic [31:0] dat;
    logic        last;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
  } beat_t;

  vec_t  vec [NW];
  beat_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int mon_beat = 0;
  int stall_len [NW];
  bit stall_used [NW];
  int stall_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge fclk);
    #1;
  endtask

  task automatic push_set(input bit ovr7, input logic [31:0] dat7);
    for (int w = 0; w < NW; w++) begin
      beat_t b;
      b.dat  = (ovr7 && w == NW - 1) ? dat7 : vec[w].dat;
      b.last = vec[w].last;
      exp_q.push_back(b);
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 200) begin
      tick;
      c++;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  task automatic wait_beat(input int n);
    int k = 0;
    while (mon_beat != n && k < 100) begin
      tick;
      k++;
    end
    chk("reach_beat", mon_beat, n);
  endtask

  // Monitor: the handshake seen at the falling edge completes on the next rising edge.
  logic        prev_st = 1'b0;
  logic [31:0] prev_dat;
  logic        prev_last;
  always @(negedge fclk) begin
    if (rst) begin
      mon_beat = 0;
      prev_st  = 1'b0;
    end else begin
      if (prev_st) begin
        chk("hold_tvalid", m_axis_tvalid, 1'b1);
        chk("hold_tdata", m_axis_tdata, prev_dat);
        chk("hold_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_beat: got %h expected none", m_axis_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e.dat);
          chk("tlast", m_axis_tlast, e.last);
          chk("tkeep", m_axis_tkeep, 4'hF);
        end
        mon_beat = m_axis_tlast ? 0 : mon_beat + 1;
      end
      prev_st   = m_axis_tvalid && !m_axis_tready;
      prev_dat  = m_axis_tdata;
      prev_last = m_axis_tlast;
    end
  end

  // Ready driver: stalls the beat index named in stall_len, once per configured beat.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      tick;
      if (stall_left == 0 && m_axis_tvalid && mon_beat < NW &&
          stall_len[mon_beat] > 0 && !stall_used[mon_beat]) begin
        stall_used[mon_beat] = 1'b1;
        stall_left = stall_len[mon_beat];
      end
      if (stall_left > 0) begin
        m_axis_tready = 1'b0;
        stall_left--;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    vec[0] = '{8'h00, 8'h01, 8'h02, 8'h03, 32'h03020100, 1'b0};
    vec[1] = '{8'h04, 8'h05, 8'h06, 8'h07, 32'h07060504, 1'b0};
    vec[2] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 32'h0B0A0908, 1'b0};
    vec[3] = '{8'h0C, 8'h0D, 8'h0E, 8'h0F, 32'h0F0E0D0C, 1'b0};
    vec[4] = '{8'h10, 8'h11, 8'h12, 8'h13, 32'h13121110, 1'b0};
    vec[5] = '{8'h14, 8'h15, 8'h16, 8'h17, 32'h17161514, 1'b0};
    vec[6] = '{8'h18, 8'h19, 8'h1A, 8'h1B, 32'h1B1A1918, 1'b0};
    vec[7] = '{8'h1C, 8'h1D, 8'h1E, 8'h1F, 32'h1F1E1D1C, 1'b1};
    for (int i = 0; i < NW; i++) begin
      stall_len[i]  = 0;
      stall_used[i] = 1'b0;
    end

    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    tick; tick; tick;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_tkeep", m_axis_tkeep, 4'hF);
    chk("rst_stall", stall_cnt, 16'h0);
    rst = 1'b0;
    tick;

    // Load the set lane by lane from the table, then stream with tready held high.
    for (int w = 0; w < NW; w++) begin
      logic [7:0] el [4];
      el[0] = vec[w].e0; el[1] = vec[w].e1; el[2] = vec[w].e2; el[3] = vec[w].e3;
      for (int k = 0; k < 4; k++) begin
        ld_en = 1'b1; ld_addr = 5'(w * 4 + k); ld_data = el[k];
        tick;
      end
    end
    ld_en = 1'b0;
    push_set(1'b0, 32'h0);
    do_start;
    chk("lat_tvalid", m_axis_tvalid, 1'b1);
    chk("lat_busy", busy, 1'b1);
    chk("lat_tdata", m_axis_tdata, 32'h03020100);
    wait_done(c);
    chk("done_cycles", c, 8);
    chk("done_busy", busy, 1'b1);
    chk("done_tvalid", m_axis_tvalid, 1'b0);
    chk("q_empty1", exp_q.size(), 0);
    tick;
    chk("done_pulse", done, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Backpressure: 3 cycles on beat 2, 2 cycles on beat 7.
    stall_len[2] = 3; stall_len[7] = 2;
    push_set(1'b0, 32'h0);
    do_start;
    wait_done(c);
    chk("stall_cycles", c, 13);
`ifdef MM_FEEDER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 16'd5);
`else
    chk("stall_cnt", stall_cnt, 16'd0);
`endif
    tick;
`ifdef MM_FEEDER_STALL_CNT_EN
    chk("stall_hold", stall_cnt, 16'd5);
`else
    chk("stall_hold", stall_cnt, 16'd0);
`endif
    chk("q_empty2", exp_q.size(), 0);
    stall_len[2] = 0; stall_len[7] = 0;

    // start and a write to addr 0 while streaming are both ignored.
    push_set(1'b0, 32'h0);
    do_start;
    wait_beat(4);
    start = 1'b1; ld_en = 1'b1; ld_addr = 5'd0; ld_data = 8'hAA;
    tick;
    start = 1'b0; ld_en = 1'b0;
    chk("midstart_busy", busy, 1'b1);
    wait_done(c);
    chk("q_empty3", exp_q.size(), 0);

    // Two packets, each start issued the cycle after done.
    tick;
    push_set(1'b0, 32'h0);
    do_start;
    chk("dropped_write", m_axis_tdata, 32'h03020100);
    wait_done(c);
    chk("b2b_cycles1", c, 8);
    tick;
    push_set(1'b0, 32'h0);
    do_start;
    wait_done(c);
    chk("b2b_cycles2", c, 8);
    chk("q_empty4", exp_q.size(), 0);
    tick;

    // Reset during beat 5 aborts cleanly; memory survives.
    push_set(1'b0, 32'h0);
    do_start;
    wait_beat(5);
    rst = 1'b1;
    tick;
    chk("abort_tvalid", m_axis_tvalid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_tlast", m_axis_tlast, 1'b0);
    rst = 1'b0;
    chk("abort_left", exp_q.size(), 3);
    exp_q.delete();
    tick;
    push_set(1'b0, 32'h0);
    do_start;
    wait_done(c);
    chk("post_rst_cycles", c, 8);
    chk("q_empty5", exp_q.size(), 0);
    tick;

    // Write and start in the same idle cycle.
    push_set(1'b1, 32'h551E1D1C);
    ld_en = 1'b1; ld_addr = 5'd31; ld_data = 8'h55; start = 1'b1;
    tick;
    ld_en = 1'b0; start = 1'b0;
    wait_done(c);
    chk("same_cyc_cycles", c, 8);
    chk("q_empty6", exp_q.size(), 0);
    tick; tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
